// File: rtl/stream_exec_ctrl.sv
// Execution sequencer between the host port and streams_top: arbitrates host io access in idle
// and runs the reset / enable / done sequence of one execution with cycle counting, abort and timeout.
module stream_exec_ctrl #(
  parameter int ADDR_L      = 16,
  parameter int DATA_L      = 32,
  parameter int CNT_L       = 32,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_L-1:0] host_addr,
  input  logic [DATA_L-1:0] host_wr_data,
  output logic              host_gnt,
  output logic [DATA_L-1:0] host_rd_data,
  output logic              host_rd_vld,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_L-1:0]  cycle_cnt,
  output logic [ADDR_L-1:0] full_addr_io,
  output logic [DATA_L-1:0] wr_data_io,
  output logic              wr_vld_io,
  output logic              rd_vld_io,
  input  logic [DATA_L-1:0] rd_data_io,
  input  logic              rd_data_vld_io,
  output logic              reset_execution_io,
  output logic              enable_execution_io,
  input  logic              done_execution_io,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RSTX = 3'd1,
    S_RUN  = 3'd2,
    S_ABRT = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYC - 1);
  localparam logic [CNT_L-1:0] TO_LAST  = (TIMEOUT_CYC == 0) ? '0 : CNT_L'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [RCW-1:0]      rst_cnt_q, rst_cnt_d;
  logic [CNT_L-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic                start_pend_q, start_pend_d;
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_L-1:0]   full_addr_q, full_addr_d;
  logic [DATA_L-1:0]   wr_data_q, wr_data_d;
  logic                wr_vld_q, wr_vld_d;
  logic                rd_vld_q, rd_vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rst_exec_q, rst_exec_d;
  logic                en_exec_q, en_exec_d;

  // Host handshake: an access transfers in the cycle host_req and host_gnt are both high; the io
  // strobe follows one cycle later. Only one read may be outstanding, and start outranks the host.
  always_comb begin
    host_gnt = host_req & (state_q == S_IDLE) & ~rd_pend_q & ~start & ~start_pend_q;
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    timeout_err_d = timeout_err_q;
    start_pend_d  = start_pend_q;
    rd_pend_d     = rd_pend_q;
    full_addr_d   = full_addr_q;
    wr_data_d     = wr_data_q;
    wr_vld_d      = 1'b0;
    rd_vld_d      = 1'b0;

    if (rd_pend_q && rd_data_vld_io) rd_pend_d = 1'b0;
    if (host_gnt) begin
      full_addr_d = host_addr;
      wr_data_d   = host_wr_data;
      wr_vld_d    = host_wr;
      rd_vld_d    = ~host_wr;
      if (!host_wr) rd_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if ((start || start_pend_q) && !rd_pend_q) begin
          state_d       = S_RSTX;
          rst_cnt_d     = '0;
          cycle_cnt_d   = '0;
          timeout_err_d = 1'b0;
          start_pend_d  = 1'b0;
        end else if (start) begin
          start_pend_d = 1'b1;
        end
      end
      S_RSTX: begin
        if (abort)                      state_d = S_FIN;
        else if (rst_cnt_q == RST_LAST) state_d = S_RUN;
        else                            rst_cnt_d = rst_cnt_q + RCW'(1);
      end
      S_RUN: begin
        cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_L'(1);
        // Normal completion outranks abort, which outranks timeout.
        if (done_execution_io) begin
          state_d = S_FIN;
        end else if (abort) begin
          state_d = S_ABRT;
        end else if (TIMEOUT_CYC != 0 && cycle_cnt_q == TO_LAST) begin
          state_d       = S_ABRT;
          timeout_err_d = 1'b1;
        end
      end
      S_ABRT:  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    rst_exec_d = (state_d == S_RSTX) || (state_d == S_ABRT);
    en_exec_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      start_pend_q  <= 1'b0;
      rd_pend_q     <= 1'b0;
      full_addr_q   <= '0;
      wr_data_q     <= '0;
      wr_vld_q      <= 1'b0;
      rd_vld_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rst_exec_q    <= 1'b0;
      en_exec_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      timeout_err_q <= timeout_err_d;
      start_pend_q  <= start_pend_d;
      rd_pend_q     <= rd_pend_d;
      full_addr_q   <= full_addr_d;
      wr_data_q     <= wr_data_d;
      wr_vld_q      <= wr_vld_d;
      rd_vld_q      <= rd_vld_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rst_exec_q    <= rst_exec_d;
      en_exec_q     <= en_exec_d;
    end
  end

  assign host_rd_data        = rd_data_io;
  assign host_rd_vld         = rd_data_vld_io & rd_pend_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign timeout_err         = timeout_err_q;
  assign cycle_cnt           = cycle_cnt_q;
  assign full_addr_io        = full_addr_q;
  assign wr_data_io          = wr_data_q;
  assign wr_vld_io           = wr_vld_q;
  assign rd_vld_io           = rd_vld_q;
  assign reset_execution_io  = rst_exec_q;
  assign enable_execution_io = en_exec_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_stream_exec_ctrl.sv
// Bench for stream_exec_ctrl: a default instance for host access and normal/abort runs, and a
// second instance with an 8-cycle timeout. Run summaries and read data are checked from queues.
module tb_stream_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_req = 1'b0, host_wr = 1'b0;
  logic [15:0] host_addr = '0;
  logic [31:0] host_wr_data = '0;
  logic        host_gnt, host_rd_vld;
  logic [31:0] host_rd_data;
  logic        start = 1'b0, abort = 1'b0;
  logic        busy, done, timeout_err;
  logic [31:0] cycle_cnt;
  logic [15:0] full_addr_io;
  logic [31:0] wr_data_io;
  logic        wr_vld_io, rd_vld_io;
  logic [31:0] rd_data_io = '0;
  logic        rd_data_vld_io = 1'b0;
  logic        reset_execution_io, enable_execution_io;
  logic        done_execution_io = 1'b0;
  logic [2:0]  dbg_state;

  logic        start_t = 1'b0;
  logic        zero_t = 1'b0;
  logic [15:0] zaddr_t = '0;
  logic [31:0] zdata_t = '0;
  logic        gnt_t, rd_vld_host_t, busy_t, done_t, to_err_t, wr_vld_t, rd_vld_t, rst_x_t, en_x_t;
  logic [31:0] rd_data_host_t, cnt_t, wr_data_t;
  logic [15:0] addr_t;
  logic [2:0]  dbg_t;

  int n_cmp = 0;
  int n_fail = 0;
  int rd_ret_cnt = 0;
  logic inject_spur = 1'b0;

  logic [31:0] rd_exp_q[$];
  logic [44:0] run_exp_q[$];
  logic [44:0] run_exp_t_q[$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  stream_exec_ctrl u_dut (
    .clk(clk), .rst(rst), .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_gnt(host_gnt), .host_rd_data(host_rd_data),
    .host_rd_vld(host_rd_vld), .start(start), .abort(abort), .busy(busy), .done(done),
    .timeout_err(timeout_err), .cycle_cnt(cycle_cnt), .full_addr_io(full_addr_io),
    .wr_data_io(wr_data_io), .wr_vld_io(wr_vld_io), .rd_vld_io(rd_vld_io),
    .rd_data_io(rd_data_io), .rd_data_vld_io(rd_data_vld_io),
    .reset_execution_io(reset_execution_io), .enable_execution_io(enable_execution_io),
    .done_execution_io(done_execution_io), .dbg_state(dbg_state)
  );

  stream_exec_ctrl #(.TIMEOUT_CYC(8)) u_to (
    .clk(clk), .rst(rst), .host_req(zero_t), .host_wr(zero_t), .host_addr(zaddr_t),
    .host_wr_data(zdata_t), .host_gnt(gnt_t), .host_rd_data(rd_data_host_t),
    .host_rd_vld(rd_vld_host_t), .start(start_t), .abort(abort), .busy(busy_t), .done(done_t),
    .timeout_err(to_err_t), .cycle_cnt(cnt_t), .full_addr_io(addr_t),
    .wr_data_io(wr_data_t), .wr_vld_io(wr_vld_t), .rd_vld_io(rd_vld_t),
    .rd_data_io(zdata_t), .rd_data_vld_io(zero_t),
    .reset_execution_io(rst_x_t), .enable_execution_io(en_x_t),
    .done_execution_io(zero_t), .dbg_state(dbg_t)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [44:0] mk_run(input logic to, input int rc, input int ec, input int cnt);
    return {to, 4'(rc), 8'(ec), 32'(cnt)};
  endfunction

  // streams_top stand-in: stores writes, answers reads two cycles after the strobe.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (wr_vld_io) mem[full_addr_io[7:0]] = wr_data_io;
      if (rd_vld_io) begin
        logic [7:0] a;
        a = full_addr_io[7:0];
        repeat (2) @(posedge clk);
        #2 rd_data_io = mem[a]; rd_data_vld_io = 1'b1;
        @(posedge clk);
        #2 rd_data_vld_io = 1'b0;
      end else if (inject_spur) begin
        @(posedge clk);
        #2 rd_data_io = 32'hDEAD_BEEF; rd_data_vld_io = 1'b1;
        @(posedge clk);
        #2 rd_data_vld_io = 1'b0;
        inject_spur = 1'b0;
      end
    end
  end

  // Monitor: read data and per-run summaries (reset cycles, enable cycles, count, timeout flag).
  int rc = 0, ec = 0, rc_t = 0, ec_t = 0;
  always @(negedge clk) begin
    if (!rst) begin
      rc = 0; ec = 0; rc_t = 0; ec_t = 0;
    end else begin
      if (host_rd_vld) begin
        rd_ret_cnt++;
        if (rd_exp_q.size() == 0) chk("rd_unexpected", 64'(host_rd_data), 64'hFFFF_FFFF_FFFF);
        else chk("rd_data", 64'(host_rd_data), 64'(rd_exp_q.pop_front()));
      end
      if (reset_execution_io) rc++;
      if (enable_execution_io) ec++;
      if (done) begin
        if (run_exp_q.size() == 0) chk("run_unexpected", 64'(cycle_cnt), 64'hFFFF_FFFF_FFFF);
        else chk("run_summary", 64'(mk_run(timeout_err, rc, ec, int'(cycle_cnt))),
                 64'(run_exp_q.pop_front()));
        rc = 0; ec = 0;
      end
      if (rst_x_t) rc_t++;
      if (en_x_t) ec_t++;
      if (done_t) begin
        if (run_exp_t_q.size() == 0) chk("run_t_unexpected", 64'(cnt_t), 64'hFFFF_FFFF_FFFF);
        else chk("run_t_summary", 64'(mk_run(to_err_t, rc_t, ec_t, int'(cnt_t))),
                 64'(run_exp_t_q.pop_front()));
        rc_t = 0; ec_t = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic granted, seen;
    int ret0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rst_exec", 64'(reset_execution_io), 0);
    chk("rst_en_exec", 64'(enable_execution_io), 0);
    chk("rst_cycle_cnt", 64'(cycle_cnt), 0);
    chk("rst_timeout_err", 64'(timeout_err), 0);
    chk("rst_io_vld", 64'({wr_vld_io, rd_vld_io}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xA5 @0x0012, then read it back; a second read waits for the first
    host_req = 1'b1; host_wr = 1'b1; host_addr = 16'h0012; host_wr_data = 32'h0000_00A5;
    #1 chk("wr_gnt", 64'(host_gnt), 1);
    @(negedge clk);
    host_req = 1'b0;
    chk("wr_vld_io", 64'(wr_vld_io), 1);
    chk("wr_addr_io", 64'(full_addr_io), 64'h12);
    chk("wr_data_io", 64'(wr_data_io), 64'hA5);
    chk("wr_no_rd_vld", 64'(rd_vld_io), 0);
    @(negedge clk);
    chk("wr_vld_one_cycle", 64'(wr_vld_io), 0);
    host_req = 1'b1; host_wr = 1'b0;
    #1 chk("rd_gnt", 64'(host_gnt), 1);
    rd_exp_q.push_back(32'hA5);
    @(negedge clk);
    chk("rd_vld_io", 64'(rd_vld_io), 1);
    #1 chk("rd2_blocked", 64'(host_gnt), 0);
    granted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (host_gnt) begin granted = 1'b1; break; end
    end
    chk("rd2_granted", 64'(granted), 1);
    chk("rd2_after_return", 64'(rd_ret_cnt), 1);
    rd_exp_q.push_back(32'hA5);
    @(negedge clk);
    host_req = 1'b0;
    repeat (8) @(negedge clk);

    // Read data valid with no outstanding read is ignored
    inject_spur = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (rd_data_vld_io) begin seen = 1'b1; chk("spur_ignored", 64'(host_rd_vld), 0); end
    end
    chk("spur_seen", 64'(seen), 1);
    repeat (2) @(negedge clk);

    // Normal 10-cycle run; start beats host_req; start during RUN ignored; done+abort -> normal
    start = 1'b1; host_req = 1'b1; host_wr = 1'b1; host_addr = 16'h0033;
    #1 chk("start_beats_host", 64'(host_gnt), 0);
    run_exp_q.push_back(mk_run(1'b0, 2, 10, 10));
    @(negedge clk);
    start = 1'b0; host_req = 1'b0;
    chk("rstx_busy", 64'(busy), 1);
    chk("rstx_rst_exec", 64'(reset_execution_io), 1);
    chk("rstx_state", 64'(dbg_state), 1);
    chk("rstx_no_wr", 64'(wr_vld_io), 0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (enable_execution_io) begin
        k++;
        start = (k == 3);
        if (k == 10) begin done_execution_io = 1'b1; abort = 1'b1; break; end
      end
      @(negedge clk);
    end
    chk("run_len", 64'(k), 10);
    @(negedge clk);
    done_execution_io = 1'b0; abort = 1'b0;
    chk("fin_en_low", 64'(enable_execution_io), 0);
    chk("fin_no_abrt", 64'(reset_execution_io), 0);
    chk("fin_done", 64'(done), 1);
    @(negedge clk);
    chk("fin_done_pulse", 64'(done), 0);
    chk("idle_busy", 64'(busy), 0);
    chk("cnt_10", 64'(cycle_cnt), 10);
    @(negedge clk);
    chk("start_not_queued", 64'(busy), 0);

    // Abort at RUN cycle 5
    start = 1'b1;
    run_exp_q.push_back(mk_run(1'b0, 3, 5, 5));
    @(negedge clk);
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (enable_execution_io) begin
        k++;
        if (k == 5) begin abort = 1'b1; break; end
      end
      @(negedge clk);
    end
    chk("abort_run_len", 64'(k), 5);
    @(negedge clk);
    abort = 1'b0;
    chk("abrt_rst_exec", 64'(reset_execution_io), 1);
    chk("abrt_en_low", 64'(enable_execution_io), 0);
    chk("abrt_state", 64'(dbg_state), 3);
    @(negedge clk);
    chk("abrt_rst_one", 64'(reset_execution_io), 0);
    chk("abrt_done", 64'(done), 1);
    @(negedge clk);
    chk("abrt_cnt_5", 64'(cycle_cnt), 5);
    chk("abrt_no_timeout", 64'(timeout_err), 0);
    chk("abrt_idle", 64'(busy), 0);

    // Start while a read is outstanding waits for the read data, and blocks the host meanwhile
    host_req = 1'b1; host_wr = 1'b0; host_addr = 16'h0012;
    #1 chk("pend_rd_gnt", 64'(host_gnt), 1);
    rd_exp_q.push_back(32'hA5);
    ret0 = rd_ret_cnt;
    @(negedge clk);
    start = 1'b1;
    #1 chk("pend_start_gnt", 64'(host_gnt), 0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) break;
      #1 chk("pend_gnt_blocked", 64'(host_gnt), 0);
      @(negedge clk);
    end
    chk("pend_started", 64'(busy), 1);
    chk("pend_after_rd", 64'(rd_ret_cnt), 64'(ret0 + 1));
    chk("pend_rst_exec", 64'(reset_execution_io), 1);
    host_req = 1'b0; abort = 1'b1;
    run_exp_q.push_back(mk_run(1'b0, 1, 0, 0));
    @(negedge clk);
    abort = 1'b0;
    chk("rstx_abort_fin", 64'(done), 1);
    repeat (2) @(negedge clk);

    // Timeout after 8 RUN cycles, cleared by the next start
    start_t = 1'b1;
    run_exp_t_q.push_back(mk_run(1'b1, 3, 8, 8));
    @(negedge clk);
    start_t = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_t) begin seen = 1'b1; break; end
    end
    chk("to_done_seen", 64'(seen), 1);
    @(negedge clk);
    chk("to_err_sticky", 64'(to_err_t), 1);
    chk("to_cnt_8", 64'(cnt_t), 8);
    chk("to_idle", 64'(busy_t), 0);
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    chk("to_err_cleared", 64'(to_err_t), 0);
    chk("to_restart_busy", 64'(busy_t), 1);
    abort = 1'b1;
    run_exp_t_q.push_back(mk_run(1'b0, 1, 0, 0));
    @(negedge clk);
    abort = 1'b0;
    chk("to_rstx_abort_done", 64'(done_t), 1);
    chk("abort_idle_no_effect", 64'(busy), 0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_en", 64'(enable_execution_io), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_en_low", 64'(enable_execution_io), 0);
    chk("arst_busy_low", 64'(busy), 0);
    chk("arst_cnt_zero", 64'(cycle_cnt), 0);
    chk("arst_rst_exec", 64'(reset_execution_io), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'(busy), 0);

    repeat (4) @(negedge clk);
    chk("rd_q_empty", 64'(rd_exp_q.size()), 0);
    chk("run_q_empty", 64'(run_exp_q.size()), 0);
    chk("run_t_q_empty", 64'(run_exp_t_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
